uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Controller that sequences the 16x-oversampling UART receiver. It generates the receiver's `rx_clk_en` sampling strobe from `sys_clk` using a programmable divisor. It detects each completed byte via `rx_ready`, pushes the byte into a local FIFO and issues the one-cycle `rx_ready_clear` acknowledge. It sits between the receiver and the host-side consumer (CPU bus or loopback logic) and flags overrun when bytes arrive faster than they are drained.

## Interface
- `DIV_W`, 16: width of baud divisor.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `sys_clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `baud_div` input DIV_W: `sys_clk` cycles per `rx_clk_en` pulse (= f_clk / (16·baud)).
- `rx_clk_en` output 1: one-cycle sampling strobe to receiver.
- `rx_data` input 8: byte from receiver, valid while `rx_ready`=1.
- `rx_ready` input 1: receiver byte-complete flag (level, held until cleared).
- `rx_ready_clear` output 1: one-cycle acknowledge to receiver.
- `rd_en` input 1: consumer pop request.
- `rd_data` output 8: FIFO head (first-word fall-through).
- `fifo_empty` output 1, `fifo_full` output 1: FIFO status.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: occupancy.
- `overrun` output 1: sticky, byte dropped because FIFO full.
- `overrun_clear` input 1: clears `overrun`.

## Operation
- Divider: counter `div_cnt` counts 0..`baud_div`−1; `rx_clk_en`=1 (registered) in the cycle after `div_cnt` == `baud_div`−1, then counter wraps to 0. `baud_div` of 0 or 1 → `rx_clk_en` high every cycle. Runtime change of `baud_div`: if `div_cnt` ≥ new value−1, counter wraps to 0 next cycle (no 2^DIV_W stall).
- Capture FSM, states IDLE, ACK, WAIT_DROP:
  - IDLE: `rx_ready`=1 → push `rx_data` (or set `overrun` if full and no simultaneous pop), go ACK.
  - ACK: `rx_ready_clear`=1 for exactly this cycle; go WAIT_DROP.
  - WAIT_DROP: stay until `rx_ready`=0, then IDLE. One push per `rx_ready` assertion, never two.
- FIFO: push and pop in the same cycle both succeed, count unchanged; this includes the full case, with no overrun. Pop when empty is ignored; `rd_data` is don't-care but stable. Pointers wrap modulo FIFO_DEPTH.
- `overrun`: set on drop; `overrun_clear` clears it; if set and clear occur in the same cycle, set wins.
- Reset values: `rx_clk_en`=0, `rx_ready_clear`=0, `div_cnt`=0, state IDLE, pointers 0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overrun`=0. Reset mid-capture aborts the FSM to IDLE and discards FIFO contents. A `rx_ready` still high after reset is captured as a new byte.

## Timing
- First `rx_clk_en` after reset release: cycle `baud_div`, then period `baud_div`.
- `rx_ready` rising seen in cycle N → byte written at edge ending N. `rd_data`/`fifo_empty`=0 visible in N+1. `rx_ready_clear`=1 in cycle N+1.
- `rd_en` in cycle M → next entry on `rd_data` in M+1. Status flags update on the same edge.
- Minimum byte spacing accepted: 3 cycles (IDLE→ACK→WAIT_DROP→IDLE with `rx_ready` low).

## Structure
- Shared package `uart_pkg`: FSM state encoding (`RXC_IDLE`, `RXC_ACK`, `RXC_WAIT_DROP`), default divisor constants for supported baud rates, FIFO depth default.
- Sub-module `uart_sync_fifo` (parameterised width/depth, FWFT, count/full/empty). The divider and FSM stay in `uart_rx_ctrl`.

## Test plan
- Divider: `baud_div`=4 after reset → `rx_clk_en` pulses at cycles 4, 8, 12. `baud_div`=1 → high every cycle. Change 100→3 while `div_cnt`=50 → wrap next cycle, then period 3.
- Single byte: `rx_data`=0xA5, `rx_ready` raised at N → `rx_ready_clear` only in N+1. `rd_data`=0xA5 and `fifo_count`=1 at N+1. `rx_ready` held high 10 cycles → only one push.
- Fill: 8 bytes 0x00..0x07 with no pops → `fifo_full`=1. 9th byte 0xFF → `overrun`=1, FIFO unchanged, still acked. Pops return 0x00..0x07 in order.
- Simultaneous: FIFO full, `rd_en` in the same cycle as a capture → no overrun, count stays 8, new byte last out. `overrun_clear` together with an overrun event → `overrun` stays 1.
- Reset mid-operation: `rst` asserted in ACK with 3 bytes queued → next cycle `rx_ready_clear`=0, `fifo_empty`=1, `overrun`=0, `rx_clk_en`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: capture FSM state encoding,
// default parameter values and divisor constants for common baud rates.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Capture FSM states of uart_rx_ctrl.
  typedef enum logic [1:0] {
    RXC_IDLE      = 2'd0,
    RXC_ACK       = 2'd1,
    RXC_WAIT_DROP = 2'd2
  } rxc_state_e;

  localparam int unsigned UART_DIV_W_DEFAULT      = 16;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned UART_CLK_HZ_DEFAULT     = 50_000_000;

  // Divisor giving one rx_clk_en pulse per 1/16 bit time, rounded to nearest.
  function automatic int unsigned uart_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

  // Divisors for the default 50 MHz system clock.
  localparam int unsigned UART_DIV_9600   = uart_baud_div(UART_CLK_HZ_DEFAULT, 9600);
  localparam int unsigned UART_DIV_19200  = uart_baud_div(UART_CLK_HZ_DEFAULT, 19200);
  localparam int unsigned UART_DIV_57600  = uart_baud_div(UART_CLK_HZ_DEFAULT, 57600);
  localparam int unsigned UART_DIV_115200 = uart_baud_div(UART_CLK_HZ_DEFAULT, 115200);

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Groups the receiver-side handshake (rx_clk_en, rx_data, rx_ready,
// rx_ready_clear), the divisor setting, and the consumer-side FIFO port
// (rd_en, rd_data, status, overrun) of uart_rx_ctrl.
//   modport slave  : the controller itself
//   modport master : the environment (receiver + consumer)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W_DEFAULT,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEFAULT
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] baud_div;
  logic             rx_clk_en;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             rx_ready_clear;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overrun;
  logic             overrun_clear;

  modport slave (
    input  baud_div, rx_data, rx_ready, rd_en, overrun_clear,
    output rx_clk_en, rx_ready_clear, rd_data, fifo_empty, fifo_full,
           fifo_count, overrun
  );

  modport master (
    output baud_div, rx_data, rx_ready, rd_en, overrun_clear,
    input  rx_clk_en, rx_ready_clear, rd_data, fifo_empty, fifo_full,
           fifo_count, overrun
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO. Head entry is always visible on
// data_o; a pop advances it on the next edge. Push and pop in the same cycle
// both succeed, including when full. Pop while empty is ignored.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i  : write request and data
//   pop_i           : read request (consumes head)
//   data_o          : head entry
//   empty_o, full_o : status
//   count_o         : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap freely.
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; contents are only meaningful through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Asynchronous read of the head keeps the fall-through behaviour (LUT RAM).
  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Sequencer for a 16x-oversampling UART receiver:
//   - divides sys_clk by baud_div to produce the rx_clk_en sampling strobe
//   - captures each completed byte (rx_ready level) exactly once into a
//     local FIFO and pulses rx_ready_clear for one cycle
//   - flags a sticky overrun when a byte arrives with the FIFO full and no
//     simultaneous pop
// Ports:
//   sys_clk : system clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : uart_rx_ctrl_if.slave (baud_div, receiver handshake,
//             consumer FIFO port, overrun/overrun_clear)
// ---------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W_DEFAULT,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
  input  logic          sys_clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);

  // ---------------- baud divider ----------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             rx_clk_en_q, rx_clk_en_d;
  logic             div_hit;

  always_comb begin
    // The >= comparison makes a runtime reduction of baud_div wrap at once
    // instead of counting through the whole DIV_W range.
    div_hit     = (bus.baud_div <= DIV_W'(1)) ||
                  (div_cnt_q >= bus.baud_div - DIV_W'(1));
    div_cnt_d   = div_hit ? '0 : div_cnt_q + DIV_W'(1);
    rx_clk_en_d = div_hit;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      rx_clk_en_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      rx_clk_en_q <= rx_clk_en_d;
    end
  end

  assign bus.rx_clk_en = rx_clk_en_q;

  // ---------------- capture FSM ----------------
  rxc_state_e state_q, state_d;
  logic       push;
  logic       ack;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= RXC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RXC_IDLE:      if (bus.rx_ready) state_d = RXC_ACK;
      RXC_ACK:       state_d = RXC_WAIT_DROP;
      // Hold here until the receiver drops rx_ready so one assertion
      // yields exactly one push.
      RXC_WAIT_DROP: if (!bus.rx_ready) state_d = RXC_IDLE;
      default:       state_d = RXC_IDLE;
    endcase
  end

  always_comb begin
    push = (state_q == RXC_IDLE) && bus.rx_ready;
    ack  = (state_q == RXC_ACK);
  end

  assign bus.rx_ready_clear = ack;

  // ---------------- byte FIFO ----------------
  logic fifo_full;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.rx_data),
    .pop_i   (bus.rd_en),
    .data_o  (bus.rd_data),
    .empty_o (bus.fifo_empty),
    .full_o  (fifo_full),
    .count_o (bus.fifo_count)
  );

  assign bus.fifo_full = fifo_full;

  // ---------------- overrun ----------------
  logic overrun_q, overrun_d;
  logic drop;

  always_comb begin
    // A pop on a full FIFO frees the slot, so only full-without-pop drops.
    drop = push && fifo_full && !bus.rd_en;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;

endmodule
